// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction-memory read port, redirect/halt controls and the
// decoder-facing valid/ready instruction handshake.
interface fetch_queue_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, ir, ir_pc, ir_valid,
    input  imem_data, redirect, redirect_pc, halt, ir_ready
  );

  // Memory / decoder / control side.
  modport slave (
    input  imem_req, imem_addr, ir, ir_pc, ir_valid,
    output imem_data, redirect, redirect_pc, halt, ir_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential reads from instruction memory into a
// small PC-tagged prefetch FIFO, handed to decode over valid/ready.
// Redirects flush the queue and restart fetch; halt stops fetching until reset.
// Optional build macro FETCH_STATS_EN adds fetch_count / flush_count outputs.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
`ifdef FETCH_STATS_EN
  output logic [15:0]   fetch_count,
  output logic [15:0]   flush_count,
`endif
  fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e        state_q;
  logic [AW-1:0] fetch_pc_q;
  logic [AW-1:0] tag_q;       // address of the request whose data arrives this cycle
  logic [CW-1:0] count_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic          inflight_q;
  logic          squash_q;

  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic          running;
  logic          flow;
  logic          deq;
  logic          wr;
  logic          req;
  logic [CW-1:0] count_next;

  // Decode this cycle's queue actions; halt beats redirect, redirect beats enq/deq.
  always_comb begin
    running    = (state_q == StRun) && !reset;
    flow       = running && !bus.halt && !bus.redirect;
    deq        = flow && (count_q != '0) && bus.ir_ready;
    wr         = flow && inflight_q && !squash_q;
    count_next = count_q + CW'(wr) - CW'(deq);
    // Credit check: the word requested now lands next cycle and needs a free slot.
    req        = flow && (count_next < CW'(DEPTH));
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.ir_valid  = (count_q != '0);
  assign bus.ir        = bus.ir_valid ? data_mem[head_q] : '0;
  assign bus.ir_pc     = bus.ir_valid ? pc_mem[head_q]   : '0;

  // Fetch control FSM: pointers, occupancy, fetch PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= '0;
      tag_q      <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.halt) begin
            state_q    <= StHalted;
            count_q    <= '0;
            head_q     <= tail_q;
            inflight_q <= 1'b0;
            squash_q   <= 1'b1;
          end else if (bus.redirect) begin
            fetch_pc_q <= bus.redirect_pc;
            count_q    <= '0;
            head_q     <= tail_q;
            inflight_q <= 1'b0;
            squash_q   <= 1'b1;
          end else begin
            count_q    <= count_next;
            inflight_q <= req;
            squash_q   <= 1'b0;
            if (deq) head_q <= head_q + PW'(1);
            if (wr)  tail_q <= tail_q + PW'(1);
            if (req) begin
              tag_q      <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_q + AW'(1);
            end
          end
        end
        StHalted: begin
          inflight_q <= 1'b0;
          squash_q   <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage: returned word and its request address written at the tail.
  always_ff @(posedge clk) begin
    if (wr) begin
      data_mem[tail_q] <= bus.imem_data;
      pc_mem[tail_q]   <= tag_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count_q;
  logic [15:0] flush_count_q;
  logic [16:0] flush_sum;

  // Words discarded by a redirect: queued entries plus the response in flight.
  always_comb begin
    flush_sum = {1'b0, flush_count_q} + 17'(count_q) + 17'(inflight_q);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (wr && (fetch_count_q != 16'hFFFF)) fetch_count_q <= fetch_count_q + 16'd1;
      if (running && !bus.halt && bus.redirect) begin
        flush_count_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

  // The credit rule must keep occupancy within the FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));

  // A stalled head must hold steady until it is taken or flushed.
  a_head_stable: assert property (@(posedge clk) disable iff (reset)
    (flow && bus.ir_valid && !bus.ir_ready)
      |=> (bus.ir_valid && $stable(bus.ir) && $stable(bus.ir_pc)));

endmodule
